// File: rtl/aes_v2_round_pkg.sv
// Shared types and helpers for the aes_v2 round sequencer: FSM encoding,
// column-index width and byte/column extraction from the packed 128-bit state.
package aes_v2_round_pkg;

    localparam int COL_W = 2;
    localparam logic [COL_W-1:0] COL_LAST = '1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SUB  = 3'd1,
        ST_MIX  = 3'd2,
        ST_KEY  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Column c occupies bits [32c+31:32c]; row r is byte r within that column.
    function automatic logic [7:0] get_byte(input logic [127:0] st,
                                            input logic [COL_W-1:0] c,
                                            input logic [1:0] r);
        return st[{c, r, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] get_col(input logic [127:0] st,
                                            input logic [COL_W-1:0] c);
        return st[{c, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/aes_v2_round_seq_if.sv
// Host-side request/response bus and FU-side operation bus of the round sequencer.
// Every channel is valid/ready: a transfer happens on a rising clock edge where both are high; the
// initiator holds payload stable from valid rising until that edge; ready may arrive before or after valid.
interface aes_v2_round_req_if;
    logic         req_valid;
    logic         req_ready;
    logic         req_enc;
    logic         req_last;
    logic [127:0] req_state;
    logic [127:0] req_key;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_state;

    modport master (
        output req_valid, req_enc, req_last, req_state, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_state
    );
    modport slave (
        input  req_valid, req_enc, req_last, req_state, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_state
    );
endinterface

interface aes_v2_round_fu_if;
    logic        fu_valid;
    logic        fu_sub;
    logic        fu_enc;
    logic [31:0] fu_rs1;
    logic [31:0] fu_rs2;
    logic        fu_ready;
    logic [31:0] fu_rd;

    modport master (
        output fu_valid, fu_sub, fu_enc, fu_rs1, fu_rs2,
        input  fu_ready, fu_rd
    );
    modport slave (
        input  fu_valid, fu_sub, fu_enc, fu_rs1, fu_rs2,
        output fu_ready, fu_rd
    );
endinterface

// File: rtl/aes_v2_round_pack.sv
// Combinational FU operand packer: (Inv)ShiftRows byte gather for sub ops, plain column for mix ops.
// The decrypt column rotation exists only when AES_V2_ROUND_DECRYPT_EN is defined.
module aes_v2_round_pack
    import aes_v2_round_pkg::*;
(
    input  logic [127:0]     i_st,
    input  logic [COL_W-1:0] i_col,
`ifdef AES_V2_ROUND_DECRYPT_EN
    input  logic             i_enc,
`endif
    input  logic             i_sub,
    output logic [31:0]      o_rs1,
    output logic [31:0]      o_rs2
);
    logic [COL_W-1:0] w_c1;
    logic [COL_W-1:0] w_c2;
    logic [COL_W-1:0] w_c3;

    // Decrypt uses c-1/c-2/c-3, which mod 4 equal c+3/c+2/c+1.
    always_comb begin
        w_c2 = i_col + 2'd2;
`ifdef AES_V2_ROUND_DECRYPT_EN
        w_c1 = i_enc ? i_col + 2'd1 : i_col + 2'd3;
        w_c3 = i_enc ? i_col + 2'd3 : i_col + 2'd1;
`else
        w_c1 = i_col + 2'd1;
        w_c3 = i_col + 2'd3;
`endif
    end

    always_comb begin
        o_rs1 = get_col(i_st, i_col);
        o_rs2 = get_col(i_st, i_col);
        if (i_sub) begin
            o_rs1 = {8'h00, get_byte(i_st, w_c2, 2'd2), 8'h00, get_byte(i_st, i_col, 2'd0)};
            o_rs2 = {get_byte(i_st, w_c3, 2'd3), 8'h00, get_byte(i_st, w_c1, 2'd1), 8'h00};
        end
    end

endmodule

// File: rtl/aes_v2_round_seq.sv
// One AES round on a 128-bit state via the shared aes_v2 FU: 4 sub ops, 4 mix ops, local key XOR.
// Decrypt rounds are built only when AES_V2_ROUND_DECRYPT_EN is defined; otherwise every round encrypts.
module aes_v2_round_seq
    import aes_v2_round_pkg::*;
(
    input  logic              g_clk,
    input  logic              g_resetn,
    aes_v2_round_req_if.slave host,
    aes_v2_round_fu_if.master fu,
    output state_t            o_dbg_state
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [127:0]     r_st;
    logic [127:0]     r_tmp;
    logic [127:0]     r_key;
    logic [COL_W-1:0] r_col;
    logic             r_last;
    logic             w_enc;
    logic             w_fu_valid;
    logic             w_col_end;
    logic [31:0]      w_rs1;
    logic [31:0]      w_rs2;

`ifdef AES_V2_ROUND_DECRYPT_EN
    logic             r_enc;
    assign w_enc = r_enc;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_enc <= 1'b1;
        end else if (r_state == ST_IDLE && host.req_valid) begin
            r_enc <= host.req_enc;
        end
    end
`else
    assign w_enc = 1'b1;
`endif

    assign w_col_end = (r_col == COL_LAST);

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (host.req_valid) w_state_nxt = ST_SUB;
            ST_SUB:  if (fu.fu_ready && w_col_end) w_state_nxt = (w_enc && !r_last) ? ST_MIX : ST_KEY;
            ST_MIX:  if (fu.fu_ready && w_col_end) w_state_nxt = w_enc ? ST_KEY : ST_DONE;
`ifdef AES_V2_ROUND_DECRYPT_EN
            ST_KEY:  w_state_nxt = (!w_enc && !r_last) ? ST_MIX : ST_DONE;
`else
            ST_KEY:  w_state_nxt = ST_DONE;
`endif
            ST_DONE: if (host.rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // SUB collects into r_tmp so later columns still read the pre-round bytes from r_st.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_st   <= '0;
            r_tmp  <= '0;
            r_key  <= '0;
            r_col  <= '0;
            r_last <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (host.req_valid) begin
                    r_st   <= host.req_state;
                    r_key  <= host.req_key;
                    r_last <= host.req_last;
                    r_col  <= '0;
                end
                ST_SUB: if (fu.fu_ready) begin
                    r_tmp[{r_col, 5'b00000} +: 32] <= fu.fu_rd;
                    r_col <= r_col + 2'd1;
                    if (w_col_end) r_st <= {fu.fu_rd, r_tmp[95:0]};
                end
                ST_MIX: if (fu.fu_ready) begin
                    r_st[{r_col, 5'b00000} +: 32] <= fu.fu_rd;
                    r_col <= r_col + 2'd1;
                end
                ST_KEY: r_st <= r_st ^ r_key;
                default: ;
            endcase
        end
    end

    aes_v2_round_pack u_pack (
        .i_st  (r_st),
        .i_col (r_col),
`ifdef AES_V2_ROUND_DECRYPT_EN
        .i_enc (r_enc),
`endif
        .i_sub (r_state == ST_SUB),
        .o_rs1 (w_rs1),
        .o_rs2 (w_rs2)
    );

    assign w_fu_valid     = (r_state == ST_SUB) || (r_state == ST_MIX);
    assign fu.fu_valid    = w_fu_valid;
    assign fu.fu_sub      = (r_state == ST_SUB);
    assign fu.fu_enc      = w_fu_valid & w_enc;
    assign fu.fu_rs1      = w_fu_valid ? w_rs1 : 32'h0;
    assign fu.fu_rs2      = w_fu_valid ? w_rs2 : 32'h0;

    assign host.req_ready = (r_state == ST_IDLE);
    assign host.rsp_valid = (r_state == ST_DONE);
    assign host.rsp_state = r_st;

    assign o_dbg_state    = r_state;

endmodule

// File: doc/aes_v2_round_seq.md
Name: aes_v2_round_seq

Overview:
- Initiator-side sequencer for the aes_v2 functional-unit (FU) interface: valid/sub/enc/rs1/rs2 out, ready/rd in.
- Executes one complete AES round on a 128-bit state:
  - Encrypt: SubBytes+ShiftRows, MixColumns, AddRoundKey.
  - Decrypt: InvShiftRows+InvSubBytes, AddRoundKey, InvMixColumns.
- Issues 4 sub ops and 4 mix ops, then XORs the round key locally.
- Sits between a host round-loop controller and the shared FU, so cipher and ISE paths reuse one datapath.

Parameters:
- None. Configuration is via the optional-feature macro only.

Ports:
- g_clk       in   1    clock.
- g_resetn    in   1    reset. One clock; reset is asynchronous and active-low.
- req_valid   in   1    round request valid.
- req_ready   out  1    sequencer can accept a request.
- req_enc     in   1    1 = encrypt round, 0 = decrypt round.
- req_last    in   1    final round: skip the (Inv)MixColumns phase.
- req_state   in   128  input state; column c = bits [32c+31:32c], row r = byte r of the column; FIPS byte 0 at [7:0].
- req_key     in   128  round key, same packing as req_state.
- rsp_valid   out  1    result valid.
- rsp_ready   in   1    host accepts the result.
- rsp_state   out  128  result state.
- fu_valid    out  1    FU request valid.
- fu_sub      out  1    1 = sub op, 0 = mix op.
- fu_enc      out  1    FU direction.
- fu_rs1      out  32   FU operand 1.
- fu_rs2      out  32   FU operand 2.
- fu_ready    in   1    FU result valid this cycle.
- fu_rd       in   32   FU result.

Behaviour:
- FU contract:
  - Sub op: rd = {S(rs2[31:24]), S(rs1[23:16]), S(rs2[15:8]), S(rs1[7:0]))}. S is the inverse S-box when fu_enc = 0.
  - Mix op: (Inv)MixColumns of column {rs2[31:24], rs2[23:16], rs1[15:8], rs1[7:0]}.
  - A transfer completes on fu_valid && fu_ready. fu_ready may be asserted in the same cycle as fu_valid or after any number of cycles.
- Registers: st (128), tmp (128), col (2 bits), enc_q, last_q.
- States:
  - IDLE:
    - req_ready = 1.
    - On req_valid: capture state/key/enc/last, col = 0, go to SUB.
  - SUB:
    - fu_sub = 1.
    - Encrypt operands: rs1 = {8'h0, st[c+2][2], 8'h0, st[c][0]}, rs2 = {st[c+3][3], 8'h0, st[c+1][1], 8'h0}.
    - Decrypt operands: the same with column indices c-2, c-3, c-1 in place of c+2, c+3, c+1.
    - All column indices are mod 4.
    - On each handshake: tmp[c] = fu_rd and col increments.
    - On the handshake at col = 3: st = tmp (including the new word), col = 0, then:
      - encrypt, not last: go to MIX.
      - otherwise: go to KEY.
  - MIX:
    - fu_sub = 0; rs1 = rs2 = st[c].
    - On each handshake: st[c] = fu_rd.
    - On the handshake at col = 3:
      - encrypt: go to KEY.
      - decrypt: go to DONE.
  - KEY:
    - One cycle: st ^= key.
    - Decrypt, not last: go to MIX.
    - Otherwise: go to DONE.
  - DONE:
    - rsp_valid = 1; rsp_state = st, held stable.
    - On rsp_ready: go to IDLE.
    - No request is accepted in this cycle.
- fu_valid = 1 only in SUB/MIX. fu_enc = enc_q.
- fu_rs1, fu_rs2, fu_sub and fu_enc are 0 whenever fu_valid = 0.
- Operands are held stable while fu_valid && !fu_ready.
- Latency, with the FU ready k cycles after fu_valid rises (k ≥ 1) and the accept edge at t0:
  - rsp_valid rises at t0 + 8k + 2 for non-last rounds, either direction.
  - rsp_valid rises at t0 + 4k + 2 for last rounds.
- Reset values: req_ready = 1 (IDLE); rsp_valid = 0; rsp_state = 0; fu_valid = 0; all FU outputs 0.
- Reset mid-operation aborts immediately. No FU transfer is counted, and fu_valid drops asynchronously.
- fu_ready while fu_valid = 0 is ignored.
- req_valid outside IDLE is ignored; the host holds it until it sees req_ready.

Optional Feature:
- Macro: AES_V2_ROUND_DECRYPT_EN.
- Defined: decrypt rounds are supported as described above.
- Undefined:
  - req_enc is ignored and treated as 1; fu_enc is tied to 1.
  - The decrypt operand muxing and the KEY-to-MIX path are removed.

Decomposition:
- Shared package aes_v2_round_pkg:
  - State encoding constants (IDLE, SUB, MIX, KEY, DONE).
  - Column-index width.
  - Byte/column extraction helper for the 128-bit state.
- Sub-module aes_v2_round_pack: combinational operand packer. Inputs st, col, enc, sub; outputs fu_rs1, fu_rs2.

Test Plan:
1. Encrypt, k = 1, last = 0:
   - Stimulus: state 193de3bea0f4e22b9ac68d2ae9f84808 (FIPS-197 App. B round 1), key a0fafe1788542cb123a339392a6c7605.
   - Required: rsp_state a49c7ff2689f352b6b5bea43026a5049; rsp_valid at t0 + 10.
2. Last-round round trip:
   - Stimulus: encrypt last with key 0 on 193de3be…; feed the result into decrypt last with key 0.
   - Required: returns 193de3bea0f4e22b9ac68d2ae9f84808; each round completes at t0 + 6.
3. FU stall, k = 3:
   - Stimulus: repeat test 1 with an FU that takes 3 cycles per op.
   - Required: same result; rsp_valid at t0 + 26; fu_rs1/rs2 stable across stalls; exactly 8 handshakes.
4. Backpressure:
   - Stimulus: rsp_ready low for 5 cycles.
   - Required: rsp_valid and rsp_state held; req_ready = 0 until the cycle after the rsp handshake.
5. Reset mid-operation:
   - Stimulus: drop g_resetn during MIX col = 2.
   - Required: fu_valid = 0 and rsp_valid = 0 immediately; req_ready = 1 after release; the next request gives the correct result.
6. Macro undefined:
   - Stimulus: req_enc = 0 with test 1 stimulus.
   - Required: behaves as encrypt; fu_enc = 1 on all ops.
